hazard_ctrl: RTL and testbench

//  Pipeline hazard controller for the 5-stage RV32I core. Tracks destination tags of in-flight

---
 rtl/rv32_pipe_pkg.sv | 16 +
 rtl/hazard_tag_pipe.sv | 32 +++
 rtl/hazard_ctrl.sv | 88 ++++++++
 tb/tb_hazard_ctrl.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/rv32_pipe_pkg.sv
// rv32_pipe_pkg: shared forwarding-select codes, destination-tag type and tag match helper
package rv32_pipe_pkg;
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;
  localparam logic [4:0] REG_X0  = 5'd0;
  typedef struct packed {
    logic [4:0] rd;
    logic       wr;
    logic       ld;
  } hz_tag_t;
  // x0 is hardwired to zero, so a tag naming x0 can never be a real producer
  function automatic logic tag_match(input hz_tag_t t, input logic [4:0] rs, input logic use_rs);
    return use_rs && t.wr && (t.rd != REG_X0) && (t.rd == rs);
  endfunction
endpackage

// File: rtl/hazard_tag_pipe.sv
// hazard_tag_pipe: E/M/W destination-tag shift register with bubble insert on entry to E
//   clk, rst_n        clock, async active-low reset (clears all tags)
//   i_bubble          load an empty tag into E instead of i_tag
//   i_tag             tag of the instruction leaving D
//   o_e, o_m, o_w     tags currently held in E, M, W
module hazard_tag_pipe
  import rv32_pipe_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    i_bubble,
  input  hz_tag_t i_tag,
  output hz_tag_t o_e,
  output hz_tag_t o_m,
  output hz_tag_t o_w
);
  hz_tag_t r_e, r_m, r_w;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e <= '0;
      r_m <= '0;
      r_w <= '0;
    end else begin
      r_w <= r_m;
      r_m <= r_e;
      r_e <= i_bubble ? '0 : i_tag;
    end
  end
  assign o_e = r_e;
  assign o_m = r_m;
  assign o_w = r_w;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use/RAW stall, redirect flush and registered forwarding selects for a 5-stage RV32I pipe
//   clk, rst_n                      clock, async active-low reset
//   id_rs1/id_rs2, id_use_rs1/2     D-stage source registers and their use flags
//   id_rd, id_reg_write, id_is_load D-stage destination tag
//   ex_jb                           redirect resolved in E this cycle
//   stall_pc, stall_d, flush_d      PC / IF-ID controls (combinational)
//   bubble_e                        insert bubble into ID/EX at next edge
//   fwd_rs1_sel, fwd_rs2_sel        E-stage operand selects (registered with the instruction)
//   stall_cycles, flush_cycles      wrapping performance counters
module hazard_ctrl
  import rv32_pipe_pkg::*;
#(
  parameter bit FORWARD_EN = 1'b1,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_reg_write,
  input  logic             id_is_load,
  input  logic             ex_jb,
  output logic             stall_pc,
  output logic             stall_d,
  output logic             flush_d,
  output logic             bubble_e,
  output logic [1:0]       fwd_rs1_sel,
  output logic [1:0]       fwd_rs2_sel,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cycles
);
  hz_tag_t          w_id_tag, w_e, w_m, w_w;
  logic             w_m1_e, w_m2_e, w_m1_m, w_m2_m;
  logic             w_haz, w_stall, w_no_fwd, w_unused;
  logic [1:0]       w_sel1, w_sel2;
  logic [1:0]       r_sel1, r_sel2;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  assign w_id_tag = '{rd: id_rd, wr: id_reg_write, ld: id_is_load};
  hazard_tag_pipe u_tags (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_bubble (bubble_e),
    .i_tag    (w_id_tag),
    .o_e      (w_e),
    .o_m      (w_m),
    .o_w      (w_w)
  );
  // W never stalls or forwards: the regfile writes before it is read in the same cycle
  assign w_unused = ^{w_w, w_m.ld};
  always_comb begin
    w_m1_e   = tag_match(w_e, id_rs1, id_use_rs1);
    w_m2_e   = tag_match(w_e, id_rs2, id_use_rs2);
    w_m1_m   = tag_match(w_m, id_rs1, id_use_rs1);
    w_m2_m   = tag_match(w_m, id_rs2, id_use_rs2);
    w_haz    = FORWARD_EN ? ((w_m1_e || w_m2_e) && w_e.ld)
                          : (w_m1_e || w_m2_e || w_m1_m || w_m2_m);
    // a redirect squashes the dependent instruction, so it wins over the stall
    w_stall  = w_haz && !ex_jb;
    w_no_fwd = w_stall || ex_jb || !FORWARD_EN;
    // the producer seen in E/M now sits in M/W once the consumer reaches E
    w_sel1   = w_no_fwd ? FWD_REG : w_m1_e ? FWD_MEM : w_m1_m ? FWD_WB : FWD_REG;
    w_sel2   = w_no_fwd ? FWD_REG : w_m2_e ? FWD_MEM : w_m2_m ? FWD_WB : FWD_REG;
  end
  assign stall_pc     = w_stall;
  assign stall_d      = w_stall;
  assign flush_d      = ex_jb;
  assign bubble_e     = w_stall || ex_jb;
  assign fwd_rs1_sel  = r_sel1;
  assign fwd_rs2_sel  = r_sel2;
  assign stall_cycles = r_stall_cnt;
  assign flush_cycles = r_flush_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel1      <= FWD_REG;
      r_sel2      <= FWD_REG;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_sel1      <= w_sel1;
      r_sel2      <= w_sel2;
      r_stall_cnt <= r_stall_cnt + CNT_W'(w_stall);
      r_flush_cnt <= r_flush_cnt + CNT_W'(ex_jb);
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scoreboard bench for hazard_ctrl with forwarding on and off
module tb_hazard_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic        id_use_rs1 = 0, id_use_rs2 = 0, id_reg_write = 0, id_is_load = 0, ex_jb = 0;
  logic        s_pc1, s_d1, f_d1, b_e1, s_pc0, s_d0, f_d0, b_e0;
  logic [1:0]  f1_1, f2_1, f1_0, f2_0;
  logic [31:0] sc1, fc1, sc0, fc0;
  int          n_cmp = 0, n_bad = 0;
  typedef struct {
    string       nm;
    bit          fe0;
    logic [7:0]  ctl;
    int          sc;
    int          fc;
  } exp_t;
  exp_t q[$];
  event ev_chk;

  always #5 clk = ~clk;

  hazard_ctrl #(.FORWARD_EN(1'b1), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .ex_jb(ex_jb), .stall_pc(s_pc1), .stall_d(s_d1), .flush_d(f_d1), .bubble_e(b_e1),
    .fwd_rs1_sel(f1_1), .fwd_rs2_sel(f2_1), .stall_cycles(sc1), .flush_cycles(fc1));

  hazard_ctrl #(.FORWARD_EN(1'b0), .CNT_W(32)) dut0 (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .ex_jb(ex_jb), .stall_pc(s_pc0), .stall_d(s_d0), .flush_d(f_d0), .bubble_e(b_e0),
    .fwd_rs1_sel(f1_0), .fwd_rs2_sel(f2_0), .stall_cycles(sc0), .flush_cycles(fc0));

  initial forever begin
    @(negedge clk or ev_chk);
    if (q.size() != 0) begin
      exp_t e;
      logic [7:0] act;
      int asc, afc;
      e   = q.pop_front();
      act = e.fe0 ? {s_pc0, s_d0, f_d0, b_e0, f1_0, f2_0} : {s_pc1, s_d1, f_d1, b_e1, f1_1, f2_1};
      asc = e.fe0 ? int'(sc0) : int'(sc1);
      afc = e.fe0 ? int'(fc0) : int'(fc1);
      n_cmp++;
      if (act !== e.ctl || asc != e.sc || afc != e.fc) begin
        n_bad++;
        $display("FAIL %s: got {stall_pc,stall_d,flush_d,bubble_e,fwd1,fwd2}=%b sc=%0d fc=%0d, want %b sc=%0d fc=%0d",
                 e.nm, act, asc, afc, e.ctl, e.sc, e.fc);
      end
    end
  end

  task automatic push(input string nm, input bit fe0, input bit s, input bit jb, input bit b,
                      input logic [1:0] f1, input logic [1:0] f2, input int sc, input int fc);
    exp_t e;
    e.nm  = nm;
    e.fe0 = fe0;
    e.ctl = {s, s, jb, b, f1, f2};
    e.sc  = sc;
    e.fc  = fc;
    q.push_back(e);
  endtask

  task automatic drive(input logic [4:0] r1, input bit u1, input logic [4:0] r2, input bit u2,
                       input logic [4:0] rd, input bit wr, input bit ld, input bit jb);
    id_rs1 = r1; id_use_rs1 = u1; id_rs2 = r2; id_use_rs2 = u2;
    id_rd = rd; id_reg_write = wr; id_is_load = ld; ex_jb = jb;
  endtask

  task automatic cyc(input string nm, input logic [4:0] r1, input bit u1, input logic [4:0] r2, input bit u2,
                     input logic [4:0] rd, input bit wr, input bit ld, input bit jb,
                     input bit s, input bit b, input logic [1:0] f1, input logic [1:0] f2,
                     input int sc, input int fc, input bit fe0);
    @(posedge clk);
    #1;
    drive(r1, u1, r2, u2, rd, wr, ld, jb);
    push(nm, fe0, s, jb, b, f1, f2, sc, fc);
  endtask

  task automatic do_reset(input string nm);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    push(nm, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    ->ev_chk;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset("reset_state");
    //   name          rs1 u  rs2 u  rd wr ld jb | s  b  f1     f2     sc fc fe0
    cyc("lu_lw",       0, 0, 0, 0,  5, 1, 1, 0,   0, 0, 2'b00, 2'b00, 0, 0, 0);
    cyc("lu_stall",    5, 1, 1, 1,  6, 1, 0, 0,   1, 1, 2'b00, 2'b00, 0, 0, 0);
    cyc("lu_release",  5, 1, 1, 1,  6, 1, 0, 0,   0, 0, 2'b00, 2'b00, 1, 0, 0);
    cyc("lu_fwd_wb",   0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 2'b10, 2'b00, 1, 0, 0);
    cyc("rst_lw",      0, 0, 0, 0,  5, 1, 1, 0,   0, 0, 2'b00, 2'b00, 1, 0, 0);
    cyc("rst_stall",   5, 1, 1, 1,  6, 1, 0, 0,   1, 1, 2'b00, 2'b00, 1, 0, 0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 push("rst_mid_stall", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    ->ev_chk;
    #1 rst_n = 1'b1;
    cyc("rst_restart", 6, 1, 0, 1,  7, 1, 0, 0,   0, 0, 2'b00, 2'b00, 0, 0, 0);
    cyc("rst_fwd_mem", 0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 2'b01, 2'b00, 0, 0, 0);
    do_reset("reset_t2");
    cyc("raw_add",     0, 0, 0, 0,  5, 1, 0, 0,   0, 0, 2'b00, 2'b00, 0, 0, 0);
    cyc("raw_nostall", 5, 1, 5, 1,  7, 1, 0, 0,   0, 0, 2'b00, 2'b00, 0, 0, 0);
    cyc("raw_fwd_mem", 0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 2'b01, 2'b01, 0, 0, 0);
    do_reset("reset_t3");
    cyc("jb_lw",       0, 0, 0, 0,  5, 1, 1, 0,   0, 0, 2'b00, 2'b00, 0, 0, 0);
    cyc("jb_override", 5, 1, 1, 1,  6, 1, 0, 1,   0, 1, 2'b00, 2'b00, 0, 0, 0);
    cyc("jb_e_empty",  5, 1, 1, 1,  6, 1, 0, 0,   0, 0, 2'b00, 2'b00, 0, 1, 0);
    cyc("jb_fwd_wb",   0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 2'b10, 2'b00, 0, 1, 0);
    do_reset("reset_t4");
    cyc("x0_addi",     0, 1, 0, 0,  0, 1, 0, 0,   0, 0, 2'b00, 2'b00, 0, 0, 0);
    cyc("x0_add",      0, 1, 0, 1,  1, 1, 0, 0,   0, 0, 2'b00, 2'b00, 0, 0, 0);
    cyc("x0_lw",       0, 0, 0, 0,  0, 1, 1, 0,   0, 0, 2'b00, 2'b00, 0, 0, 0);
    cyc("x0_use_lw",   0, 1, 0, 1,  2, 1, 0, 0,   0, 0, 2'b00, 2'b00, 0, 0, 0);
    cyc("x0_fwd",      0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 2'b00, 2'b00, 0, 0, 0);
    do_reset("reset_t5");
    cyc("nf_add",      0, 0, 0, 0,  5, 1, 0, 0,   0, 0, 2'b00, 2'b00, 0, 0, 1);
    cyc("nf_stall_e",  5, 1, 2, 1,  6, 1, 0, 0,   1, 1, 2'b00, 2'b00, 0, 0, 1);
    cyc("nf_stall_m",  5, 1, 2, 1,  6, 1, 0, 0,   1, 1, 2'b00, 2'b00, 1, 0, 1);
    cyc("nf_release",  5, 1, 2, 1,  6, 1, 0, 0,   0, 0, 2'b00, 2'b00, 2, 0, 1);
    cyc("nf_fwd_reg",  0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 2'b00, 2'b00, 2, 0, 1);
    @(posedge clk);
    @(posedge clk);
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
